// File: rtl/scan_test_ctrl.sv
// Scan-chain test controller: serial load, one capture cycle, serial unload, masked compare.
// Start to done is 2*CHAIN_LEN+2 cycles; start is only sampled in IDLE and is dropped while busy.
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [CHAIN_LEN-1:0] i_pattern,
  input  logic [CHAIN_LEN-1:0] i_expected,
  input  logic [CHAIN_LEN-1:0] i_mask,
  input  logic                 i_so,
  output logic                 o_se,
  output logic                 o_sd,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CNT_W-1:0]     o_err_cnt,
  output logic [CHAIN_LEN-1:0] o_response
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  localparam logic [CHAIN_LEN-1:0] LP_MSB = {1'b1, {(CHAIN_LEN-1){1'b0}}};

  state_t               r_state;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-1:0] r_mask;
  logic [CHAIN_LEN-1:0] r_bit;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_se;
  logic                 r_sd;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [CNT_W-1:0]     r_err;

  logic [CHAIN_LEN-1:0] w_diff;
  logic [CHAIN_LEN-1:0] w_resp_nxt;
  logic [CNT_W-1:0]     w_pop;

  always_comb begin
    w_diff = (r_resp ^ r_exp) & r_mask;
    w_pop  = '0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      w_pop = w_pop + CNT_W'(w_diff[i]);
    end
  end

  // r_bit is a one-hot cursor walking MSB->LSB; it doubles as the bit counter.
  assign w_resp_nxt = i_so ? (r_resp | r_bit) : (r_resp & ~r_bit);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_exp   <= '0;
      r_mask  <= '0;
      r_bit   <= '0;
      r_resp  <= '0;
      r_se    <= 1'b0;
      r_sd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_se   <= 1'b0;
          r_sd   <= 1'b0;
          r_done <= 1'b0;
          if (i_start) begin
            r_pat   <= i_pattern;
            r_exp   <= i_expected;
            r_mask  <= i_mask;
            r_bit   <= LP_MSB;
            r_resp  <= '0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_se    <= 1'b1;
            r_sd    <= i_pattern[CHAIN_LEN-1];
            r_busy  <= 1'b1;
            r_state <= S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          if (r_bit[0]) begin
            r_se    <= 1'b0;
            r_sd    <= 1'b0;
            r_bit   <= LP_MSB;
            r_state <= S_CAPTURE;
          end else begin
            r_bit <= r_bit >> 1;
            r_pat <= {r_pat[CHAIN_LEN-2:0], r_pat[CHAIN_LEN-1]};
            r_sd  <= r_pat[CHAIN_LEN-2];
          end
        end
        S_CAPTURE: begin
          r_se    <= 1'b1;
          r_sd    <= 1'b0;
          r_state <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          r_resp <= w_resp_nxt;
          if (r_bit[0]) begin
            r_se    <= 1'b0;
            r_done  <= 1'b1;
            r_bit   <= '0;
            r_state <= S_DONE;
          end else begin
            r_bit <= r_bit >> 1;
          end
        end
        S_DONE: begin
          r_pass  <= (w_diff == '0);
          r_err   <= w_pop;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_se       = r_se;
  assign o_sd       = r_sd;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_err_cnt  = r_err;
  assign o_response = r_resp;

endmodule
